// File: rtl/bit_slice_sequencer_if.sv
// Word-in / slice-out handshake bundle for bit_slice_sequencer.
// The slave modport is the sequencer's view; master is the surrounding logic.
interface bit_slice_sequencer_if #(
    parameter int DATA_W  = 32,
    parameter int SLICE_W = 16,
    parameter int CNT_W   = 3
);
    logic               s_valid_i;
    logic               s_ready_o;
    logic [DATA_W-1:0]  s_data_i;
    logic               m_valid_o;
    logic               m_ready_i;
    logic [SLICE_W-1:0] m_data_o;
    logic [CNT_W-1:0]   m_index_o;
    logic               m_last_o;

    modport slave (
        input  s_valid_i,
        input  s_data_i,
        input  m_ready_i,
        output s_ready_o,
        output m_valid_o,
        output m_data_o,
        output m_index_o,
        output m_last_o
    );

    modport master (
        output s_valid_i,
        output s_data_i,
        output m_ready_i,
        input  s_ready_o,
        input  m_valid_o,
        input  m_data_o,
        input  m_index_o,
        input  m_last_o
    );
endinterface

// File: rtl/bit_slice_sequencer.sv
// Accepts a word and emits a configurable run of rotating-offset slices from it.
// Slice k is taken at offset start + k*stride (mod 2**OFF_W) and may wrap across the top bit.
module bit_slice_sequencer #(
    parameter int DATA_W  = 32,
    parameter int SLICE_W = 16,
    parameter int OFF_W   = 5,
    parameter int CNT_W   = 3
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [OFF_W-1:0]     cfg_start_i,
    input  logic [OFF_W-1:0]     cfg_stride_i,
    input  logic [CNT_W-1:0]     cfg_count_i,
    bit_slice_sequencer_if.slave bus,
    output logic                 busy_o,
    output logic [15:0]          slice_cnt_o
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [DATA_W-1:0]  word_q, word_d;
    logic [OFF_W-1:0]   stride_q, stride_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [OFF_W-1:0]   offset_q, offset_d;
    logic [CNT_W-1:0]   index_q, index_d;
    logic [SLICE_W-1:0] data_q, data_d;
    logic               last_q, last_d;
    logic [15:0]        cnt_q, cnt_d;

    logic               s_ready_s;
    logic               m_valid_s;
    logic               busy_s;
    logic               accept_s;
    logic               fire_s;
    logic               advance_s;
    logic [CNT_W-1:0]   cnt_eff_s;
    logic [OFF_W-1:0]   offset_nxt_s;
    logic [CNT_W-1:0]   index_nxt_s;

    // Bit j of the slice is w[(off + j) mod DATA_W]; OFF_W-bit addition gives the modulo for free.
    function automatic logic [SLICE_W-1:0] rot_slice(input logic [DATA_W-1:0] w,
                                                     input logic [OFF_W-1:0]  off);
        logic [SLICE_W-1:0] r;
        logic [OFF_W-1:0]   pos;
        r = {SLICE_W{1'b0}};
        for (int j = 0; j < SLICE_W; j++) begin
            pos  = off + OFF_W'(j);
            r[j] = w[pos];
        end
        return r;
    endfunction

    assign accept_s     = bus.s_valid_i & s_ready_s;
    assign fire_s       = m_valid_s & bus.m_ready_i;
    assign advance_s    = fire_s & ~last_q;
    assign cnt_eff_s    = (cfg_count_i == {CNT_W{1'b0}}) ? CNT_W'(1'b1) : cfg_count_i;
    assign offset_nxt_s = offset_q + stride_q;
    assign index_nxt_s  = index_q + CNT_W'(1'b1);

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: one word in, then slices until the last one is taken.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    state_d = ST_EMIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EMIT: begin
                if (fire_s && last_q) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_EMIT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State-decoded outputs; ready is held low while reset is asserted.
    always_comb begin
        s_ready_s = 1'b0;
        m_valid_s = 1'b0;
        busy_s    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                s_ready_s = ~rst_i;
            end
            ST_EMIT: begin
                m_valid_s = 1'b1;
                busy_s    = 1'b1;
            end
            default: begin
                s_ready_s = 1'b0;
            end
        endcase
    end

    // Datapath next values: load at acceptance, step offset/index on each non-last handshake.
    always_comb begin
        word_d   = word_q;
        stride_d = stride_q;
        count_d  = count_q;
        offset_d = offset_q;
        index_d  = index_q;
        data_d   = data_q;
        last_d   = last_q;
        if (accept_s) begin
            word_d   = bus.s_data_i;
            stride_d = cfg_stride_i;
            count_d  = cnt_eff_s;
            offset_d = cfg_start_i;
            index_d  = {CNT_W{1'b0}};
            data_d   = rot_slice(bus.s_data_i, cfg_start_i);
            last_d   = (cnt_eff_s == CNT_W'(1'b1));
        end else if (advance_s) begin
            offset_d = offset_nxt_s;
            index_d  = index_nxt_s;
            data_d   = rot_slice(word_q, offset_nxt_s);
            last_d   = (index_nxt_s == (count_q - CNT_W'(1'b1)));
        end else begin
            word_d = word_q;
        end
        if (fire_s) begin
            cnt_d = cnt_q + 16'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            word_q   <= {DATA_W{1'b0}};
            stride_q <= {OFF_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
            offset_q <= {OFF_W{1'b0}};
            index_q  <= {CNT_W{1'b0}};
            data_q   <= {SLICE_W{1'b0}};
            last_q   <= 1'b0;
            cnt_q    <= 16'd0;
        end else begin
            word_q   <= word_d;
            stride_q <= stride_d;
            count_q  <= count_d;
            offset_q <= offset_d;
            index_q  <= index_d;
            data_q   <= data_d;
            last_q   <= last_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.s_ready_o = s_ready_s;
    assign bus.m_valid_o = m_valid_s;
    assign bus.m_data_o  = data_q;
    assign bus.m_index_o = index_q;
    assign bus.m_last_o  = last_q;
    assign busy_o        = busy_s;
    assign slice_cnt_o   = cnt_q;

endmodule
